// File: rtl/muu_pkg.sv
// Shared types and constants for the MUU divide path: FSM states, default
// width, counter sizing and the MUU op-code map.
package muu_pkg;

  localparam int MUU_WIDTH = 32;
  localparam int MUU_CNT_W = $clog2(MUU_WIDTH + 1);

  localparam logic [3:0] MUU_OP_MULT  = 4'b0000;
  localparam logic [3:0] MUU_OP_MULTU = 4'b0001;
  localparam logic [3:0] MUU_OP_DIV   = 4'b0100;
  localparam logic [3:0] MUU_OP_DIVU  = 4'b0101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } div_state_e;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MUU_OP_DIV) || (op == MUU_OP_DIVU);
  endfunction

endpackage

// File: rtl/muu_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left by one and keep
// the trial difference when it does not go negative.
module muu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // One extra bit holds the borrow of the trial subtraction.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    if (!diff[WIDTH]) begin
      rem_out = diff[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muu_div_seq.sv
// Iterative restoring divider for the MUU: quotient to lo, remainder to hi.
// Optional MUU_DIV_EARLY_EXIT_EN skips iteration when |rs| < |rt|.
module muu_div_seq
  import muu_pkg::*;
#(
  parameter int WIDTH = MUU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_quo_q, sgn_quo_d;
  logic             sgn_rem_q, sgn_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH-1:0] step_rem, step_quo;

  // Unsigned requests never see a sign, so both result fix-ups stay off.
  assign rs_neg = is_signed & rs[WIDTH-1];
  assign rt_neg = is_signed & rt[WIDTH-1];
  assign rs_mag = rs_neg ? -rs : rs;
  assign rt_mag = rt_neg ? -rt : rt;

  muu_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // NOTE: every variable gets its hold value first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d     = rt_mag;
          quo_d     = rs_mag;
          rem_d     = '0;
          cnt_d     = CNT_W'(WIDTH);
          sgn_quo_d = rs_neg ^ rt_neg;
          sgn_rem_d = rs_neg;
          busy_d    = 1'b1;
          if (rt == '0) begin
            state_d = ZERO;
          end
`ifdef MUU_DIV_EARLY_EXIT_EN
          else if (rs_mag < rt_mag) begin
            quo_d   = '0;
            rem_d   = rs_mag;
            state_d = FIX;
          end
`endif
          else begin
            state_d = ITER;
          end
        end
      end

      ITER: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        lo_d    = sgn_quo_q ? -quo_q : quo_q;
        hi_d    = sgn_rem_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      ZERO: begin
        done_d  = 1'b1;
        dz_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  // NOTE: all datapath registers are reset so an abort leaves hi/lo at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muu_div_seq.sv
// Self-checking bench for muu_div_seq: vector table plus scoreboard, with
// hand-written sequences for divide-by-zero, busy-ignore and reset abort.
module tb_muu_div_seq;

  localparam int W = 32;
  localparam int FULL_LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] rs, rt;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  muu_div_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .rs        (rs),
    .rt        (rt),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
    int           acc;
    int           lat;
  } exp_t;

  typedef struct {
    bit           sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_done  = 0;
  int           stray   = 0;
  int           cyc     = 0;
  logic [W-1:0] m_lo = '0, m_hi = '0;
  logic         done_prev = 1'b0;
  logic [W-1:0] prev_hi = '0, prev_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mag(input bit sgn, input logic [W-1:0] x);
    return (sgn && x[W-1]) ? -x : x;
  endfunction

  task automatic model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sbv, lq, lr;
    sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sbv = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    lq  = sa / sbv;
    lr  = sa % sbv;
    q   = lq[W-1:0];
    r   = lr[W-1:0];
  endtask

  // Drive one request at a negedge and push what the DUT must return.
  task automatic issue(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] elo, input logic [W-1:0] ehi);
    exp_t e;
    e.dz  = (b == '0);
    e.acc = cyc + 1;
    if (e.dz) begin
      e.lo  = m_lo;
      e.hi  = m_hi;
      e.lat = 1;
    end else begin
      e.lo  = elo;
      e.hi  = ehi;
      m_lo  = elo;
      m_hi  = ehi;
      e.lat = FULL_LAT;
`ifdef MUU_DIV_EARLY_EXIT_EN
      if (mag(sgn, a) < mag(sgn, b)) e.lat = 1;
`endif
    end
    sb.push_back(e);
    is_signed = sgn;
    rs        = a;
    rt        = b;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (div_zero && !done) stray++;
      if (done && done_prev) stray++;
      if (!done && (hi !== prev_hi || lo !== prev_lo)) stray++;
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("lo", 64'(lo), 64'(mon_e.lo));
          check("hi", 64'(hi), 64'(mon_e.hi));
          check("div_zero", 64'(div_zero), 64'(mon_e.dz));
          check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
        end
      end
    end
    done_prev = done;
    prev_hi   = hi;
    prev_lo   = lo;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[10];

  initial begin
    logic [W-1:0] ra, rb, q, r;
    bit           rsg;
    int           n, dn;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[5] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[6] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE};
    vecs[7] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3};
    vecs[8] = '{1'b1, 32'hFFFF_FFFD,  32'd10,         32'd0,          32'hFFFF_FFFD};
    vecs[9] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; rs = '0; rt = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, each with its own constant expectation.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi);
      drain("vec");
    end

    // Random operands against an arithmetic model.
    for (int i = 0; i < 8; i++) begin
      rsg = i[0];
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      if (rb == '0) rb = 32'd3;
      model(rsg, ra, rb, q, r);
      issue(rsg, ra, rb, q, r);
      drain("rand");
    end

    // Divide by zero keeps the previous hi/lo.
    issue(1'b0, 32'd95, 32'd10, 32'd9, 32'd5);
    drain("preset");
    issue(1'b1, 32'd42, 32'd0, 32'd0, 32'd0);
    drain("div0");

    // Starts during busy are dropped; start in the done cycle is accepted.
    dn = n_done;
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    check("busy_after_accept", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      is_signed = 1'b0; rs = 32'd1; rt = 32'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
    issue(1'b0, 32'd1000, 32'd33, 32'd30, 32'd10);
    check("b2b_busy", 64'(busy), 64'd1);
    drain("b2b");
    check("done_count", 64'(n_done - dn), 64'd2);

    // Reset in the middle of an iteration aborts with no done.
    dn = n_done;
    @(negedge clk);
    is_signed = 1'b0; rs = 32'd100; rt = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    m_lo = '0;
    m_hi = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(n_done - dn), 64'd0);

    // Recovers after the abort.
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    drain("post_abort");

    check("stray_events", 64'(stray), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
